// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_divider_sub.sv
// One-bit full subtractor cell, ripple-chained by seq_divider to form the trial subtractor.
module sub_submodule (
  input  logic A_i,
  input  logic B_i,
  input  logic Borrow_i,
  output logic D_o,
  output logic Borrow_o
);

  assign D_o      = A_i ^ B_i ^ Borrow_i;
  assign Borrow_o = (~A_i & B_i) | (~(A_i ^ B_i) & Borrow_i);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_BYZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic             Start_i,
  input  logic [WIDTH-1:0] Dividend_i,
  input  logic [WIDTH-1:0] Divisor_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [WIDTH-1:0] Quotient_o,
  output logic [WIDTH-1:0] Remainder_o,
  output logic             DivByZero_o
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotSh;
  logic [WIDTH-1:0] r_partRem;
  logic [WIDTH-1:0] r_quotOut;
  logic [WIDTH-1:0] r_remOut;

  logic             w_accept;
  logic             w_zeroDiv;
  logic             w_lastIter;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_subB;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH+1:0] w_borrow;
  logic             w_restore;
  logic             w_unusedDiffMsb;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quotNext;

  assign w_accept   = Start_i && (r_state == IDLE || r_state == DONE);
  assign w_zeroDiv  = (Divisor_i == '0);
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  // Partial remainder is WIDTH+1 bits wide after the shift, so the subtractor is too.
  assign w_shifted   = {r_partRem, r_quotSh[WIDTH-1]};
  assign w_subB      = {1'b0, r_divisor};
  assign w_borrow[0] = 1'b0;

  for (genvar g = 0; g <= WIDTH; g++) begin : g_sub
    sub_submodule u_sub (
      .A_i      (w_shifted[g]),
      .B_i      (w_subB[g]),
      .Borrow_i (w_borrow[g]),
      .D_o      (w_diff[g]),
      .Borrow_o (w_borrow[g+1])
    );
  end

  assign w_restore       = w_borrow[WIDTH+1];
  assign w_unusedDiffMsb = w_diff[WIDTH];
  assign w_remNext       = w_restore ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quotNext      = {r_quotSh[WIDTH-2:0], ~w_restore};

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_nextState = IDLE;
        if (Start_i) begin
`ifdef DIV_BYZERO_DETECT_EN
          w_nextState = w_zeroDiv ? DONE : CALC;
`else
          w_nextState = CALC;
`endif
        end
      end
      CALC:    w_nextState = w_lastIter ? DONE : CALC;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_cnt     <= '0;
      r_divisor <= '0;
      r_quotSh  <= '0;
      r_partRem <= '0;
      r_quotOut <= '0;
      r_remOut  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_divisor <= Divisor_i;
      r_quotSh  <= Dividend_i;
      r_partRem <= '0;
`ifdef DIV_BYZERO_DETECT_EN
      if (w_zeroDiv) begin
        r_quotOut <= '1;
        r_remOut  <= Dividend_i;
      end
`endif
    end else if (r_state == CALC) begin
      r_cnt     <= r_cnt + CW'(1);
      r_quotSh  <= w_quotNext;
      r_partRem <= w_remNext;
      if (w_lastIter) begin
        r_quotOut <= w_quotNext;
        r_remOut  <= w_remNext;
      end
    end
  end

`ifdef DIV_BYZERO_DETECT_EN
  logic r_divByZero;

  // Only set by a zero-divisor acceptance, so it lasts exactly the one DONE cycle.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) r_divByZero <= 1'b0;
    else          r_divByZero <= w_accept && w_zeroDiv;
  end

  assign DivByZero_o = r_divByZero;
`else
  assign DivByZero_o = 1'b0;
`endif

  assign Busy_o      = (r_state == CALC);
  assign Done_o      = (r_state == DONE);
  assign Quotient_o  = r_quotOut;
  assign Remainder_o = r_remOut;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8; honours DIV_BYZERO_DETECT_EN when defined.
module tb_seq_divider;

  localparam int W = 8;

  logic         Clk_i;
  logic         Rst_n_i;
  logic         Start_i;
  logic [W-1:0] Dividend_i;
  logic [W-1:0] Divisor_i;
  logic         Busy_o;
  logic         Done_o;
  logic [W-1:0] Quotient_o;
  logic [W-1:0] Remainder_o;
  logic         DivByZero_o;

  seq_divider #(.WIDTH(W)) dut (
    .Clk_i       (Clk_i),
    .Rst_n_i     (Rst_n_i),
    .Start_i     (Start_i),
    .Dividend_i  (Dividend_i),
    .Divisor_i   (Divisor_i),
    .Busy_o      (Busy_o),
    .Done_o      (Done_o),
    .Quotient_o  (Quotient_o),
    .Remainder_o (Remainder_o),
    .DivByZero_o (DivByZero_o)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           doneCycle;
  } exp_t;

  exp_t         expQ[$];
  int           numChecks = 0;
  int           numFails  = 0;
  int           cycleCnt  = 0;
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;

`ifdef DIV_BYZERO_DETECT_EN
  localparam bit ZERO_DETECT = 1'b1;
`else
  localparam bit ZERO_DETECT = 1'b0;
`endif

  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end

  always @(posedge Clk_i) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cycleCnt);
    end
  endtask

  // Monitor: every Done_o pulse must match the oldest outstanding expectation.
  always @(negedge Clk_i) begin
    if (Done_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected Done_o", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("quotient", Quotient_o, e.q);
        checkOutput("remainder", Remainder_o, e.r);
        checkOutput("divbyzero", DivByZero_o, e.dbz);
        checkOutput("done latency", cycleCnt, e.doneCycle);
        lastQ = e.q;
        lastR = e.r;
      end
    end
  end

  // Called at a falling edge; the following rising edge is the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [W-1:0] v, input bit push);
    exp_t e;
    bit   fast;
    Start_i    = 1'b1;
    Dividend_i = d;
    Divisor_i  = v;
    @(posedge Clk_i);
    #1;
    fast = ZERO_DETECT && (v == 0);
    e.q  = (v == 0) ? {W{1'b1}} : W'(d / v);
    e.r  = (v == 0) ? d : W'(d % v);
    e.dbz = fast;
    e.doneCycle = cycleCnt + (fast ? 1 : W);
    if (push) expQ.push_back(e);
    checkOutput("busy after accept", Busy_o, !fast);
    @(negedge Clk_i);
    Start_i    = 1'b0;
    Dividend_i = W'($urandom);
    Divisor_i  = W'($urandom);
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge Clk_i);
      if (!Busy_o && !Done_o) idle = 1;
    end
    checkOutput("reached idle", idle, 1);
    checkOutput("quotient held", Quotient_o, lastQ);
    checkOutput("remainder held", Remainder_o, lastR);
  endtask

  initial begin
    bit seen;
    Rst_n_i    = 1'b0;
    Start_i    = 1'b0;
    Dividend_i = '0;
    Divisor_i  = '0;
    repeat (3) @(negedge Clk_i);
    checkOutput("reset busy", Busy_o, 0);
    checkOutput("reset done", Done_o, 0);
    checkOutput("reset quotient", Quotient_o, 0);
    checkOutput("reset remainder", Remainder_o, 0);
    checkOutput("reset divbyzero", DivByZero_o, 0);

    // Start on the first edge after reset release
    Rst_n_i = 1'b1;
    applyStimulus(8'd100, 8'd7, 1);
    waitIdle();

    applyStimulus(8'd255, 8'd1, 1);   waitIdle();
    applyStimulus(8'd3, 8'd200, 1);   waitIdle();
    applyStimulus(8'd200, 8'd200, 1); waitIdle();
    applyStimulus(8'd5, 8'd0, 1);     waitIdle();
    applyStimulus(8'd0, 8'd9, 1);     waitIdle();

    // Start during CALC must be ignored
    applyStimulus(8'd100, 8'd7, 1);
    repeat (2) @(negedge Clk_i);
    Start_i = 1'b1; Dividend_i = 8'd9; Divisor_i = 8'd2;
    @(negedge Clk_i);
    Start_i = 1'b0;
    waitIdle();

    // Back-to-back: restart during the Done_o cycle
    applyStimulus(8'd100, 8'd7, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk_i);
      if (Done_o) seen = 1;
    end
    checkOutput("first done before restart", seen, 1);
    applyStimulus(8'd50, 8'd6, 1);
    waitIdle();

    // Reset mid-operation: abort, zero outputs, no Done afterwards
    applyStimulus(8'd100, 8'd7, 0);
    repeat (3) @(negedge Clk_i);
    Rst_n_i = 1'b0;
    #1;
    checkOutput("abort busy", Busy_o, 0);
    checkOutput("abort done", Done_o, 0);
    checkOutput("abort quotient", Quotient_o, 0);
    checkOutput("abort remainder", Remainder_o, 0);
    checkOutput("abort divbyzero", DivByZero_o, 0);
    lastQ = '0;
    lastR = '0;
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    repeat (12) @(negedge Clk_i);
    checkOutput("no done after abort", Quotient_o, 0);
    applyStimulus(8'd200, 8'd13, 1);
    waitIdle();

    // Randomized operations against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] d;
      logic [W-1:0] v;
      d = W'($urandom_range(0, 255));
      v = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      applyStimulus(d, v, 1);
      waitIdle();
    end

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port Clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start_i  input  1  request to begin a division; sampled on rising edge.
REQ-005 SHALL have port Dividend_i  input  WIDTH  unsigned dividend, captured when Start_i is accepted.
REQ-006 SHALL have port Divisor_i  input  WIDTH  unsigned divisor, captured when Start_i is accepted.
REQ-007 SHALL have port Busy_o  output  1  high while an operation is in progress.
REQ-008 SHALL have port Done_o  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port Quotient_o  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port Remainder_o  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port DivByZero_o  output  1  flag accompanying Done_o when Divisor was zero.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-013 SHALL accept Start_i only in IDLE or DONE; the accepting edge is edge 0. Start_i in CALC SHALL be ignored.
REQ-014 SHALL perform restoring division, one quotient bit per cycle, MSB first: shift the partial remainder left by one, trial-subtract the divisor, restore on borrow.
REQ-015 SHALL hold CALC after edges 0..WIDTH-1, with Busy_o high during those WIDTH cycles.
REQ-016 SHALL enter DONE on edge WIDTH and assert Done_o for exactly one cycle.
REQ-017 SHALL leave DONE for IDLE on the next edge, or for CALC if Start_i is asserted then (back-to-back operation).
REQ-018 SHALL update Quotient_o and Remainder_o only on entry to DONE and hold them until the next DONE entry.
REQ-019 SHALL guarantee Dividend = Quotient*Divisor + Remainder and Remainder < Divisor for every nonzero Divisor.
REQ-020 SHALL produce Quotient_o all ones and Remainder_o = Dividend for a zero Divisor.
REQ-021 SHALL ignore input changes after acceptance; operands SHALL be internally registered.

Reset
REQ-022 SHALL, on Rst_n_i low, immediately force state IDLE and Busy_o, Done_o, DivByZero_o, Quotient_o, Remainder_o, iteration counter and internal registers to 0.
REQ-023 SHALL abort any operation in progress when reset is asserted mid-operation, with no Done_o pulse afterwards.
REQ-024 SHALL accept Start_i on the first rising edge after Rst_n_i deasserts.

Configuration
REQ-025 SHALL support macro DIV_BYZERO_DETECT_EN.
- Defined: a zero Divisor at acceptance goes directly IDLE/DONE->DONE; Done_o and DivByZero_o are high in the cycle after edge 0; results are as in REQ-020; Busy_o stays low.
- Undefined: DivByZero_o is tied 0; a zero Divisor runs the full WIDTH-cycle sequence and yields the REQ-020 values naturally.

Structure
REQ-026 SHALL place the FSM state enumeration and the default WIDTH constant in shared package div_pkg.
REQ-027 SHALL build the trial subtractor from sub-module sub_submodule, a one-bit full subtractor (A_i, B_i, Borrow_i -> D_o, Borrow_o), ripple-chained WIDTH+1 bits wide in a generate loop; the final Borrow_o selects restore.

Verification (WIDTH=8)
REQ-028 SHALL cover: Start with 100/7 -> Done_o high exactly 8 cycles after the accepting edge, Quotient 14, Remainder 2, DivByZero 0.
REQ-029 SHALL cover: 255/1 -> 255/0; 3/200 -> 0/3; 200/200 -> 1/0.
REQ-030 SHALL cover: 5/0 -> Q 8'hFF, R 5; with macro, DivByZero 1 after 1 cycle; without macro, DivByZero 0 after 8 cycles.
REQ-031 SHALL cover: Start reasserted with new operands during CALC -> ignored; results match the first operands.
REQ-032 SHALL cover: Start asserted during the Done_o cycle with 50/6 -> second Done after 8 more cycles, Q 8, R 2.
REQ-033 SHALL cover: Rst_n_i pulsed low at cycle 4 of CALC -> all outputs 0 immediately, no Done_o, next Start computes correctly.
